alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one `alu` instance between two requesters. It accepts one operation at a time over a valid/ready request port and drives the ALU's `EN`/`OE`/`OPCODE`/`A`/`B` through an issue/capture sequence. It returns the result and flags on a valid/ready response port tagged with the requester ID. It sits between the datapath clients and the ALU, and is the only block that drives the ALU's control inputs.

## Interface
- `WIDTH`, 8, operand/result width; must equal the ALU's `WIDTH`.
- `CLK` input 1: single clock; all logic on posedge.
- `RST_N` input 1: synchronous, active-low reset, sampled on posedge `CLK`.
- `REQ0_VALID`, `REQ1_VALID` input 1: requester has an operation pending.
- `REQ0_READY`, `REQ1_READY` output 1: request accepted this cycle.
- `REQ0_OP`, `REQ1_OP` input 4: opcode (`0010` ADD, `0011` SUB, `0100` AND, `0101` OR, `0110` XOR, `0111` NOT).
- `REQ0_A`, `REQ0_B`, `REQ1_A`, `REQ1_B` input WIDTH: operands.
- `RSP_VALID` output 1: response available.
- `RSP_READY` input 1: consumer takes the response.
- `RSP_ID` output 1: requester that issued the operation.
- `RSP_DATA` output WIDTH: result.
- `RSP_FLAGS` output 4: {CF, OF, SF, ZF}.
- `RSP_ERR` output 1: opcode was illegal; the operation was not executed.
- `ALU_EN`, `ALU_OE` output 1: drive the ALU's `EN`/`OE`.
- `ALU_OPCODE` output 4, `ALU_A`/`ALU_B` output WIDTH: ALU operands.
- `ALU_RESULT` input WIDTH; `ALU_CF`, `ALU_OF`, `ALU_SF`, `ALU_ZF` input 1: ALU outputs.

## Operation
- **States:** IDLE, ISSUE, CAPTURE, RESP. One operation is in flight at most.
- **IDLE / arbitration:**
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not served last. `last` resets to 1, so req0 wins first.
  - `REQx_READY` = (state==IDLE) && granted(x), combinational from the VALIDs. Never both high.
- **On handshake:**
  - Register opcode, A, B and ID; update `last`.
  - Legal opcode: go to ISSUE.
  - Illegal opcode (not `0010`–`0111`): go to RESP with `RSP_ERR`=1, `RSP_DATA`=0, `RSP_FLAGS`=0. The ALU is not touched.
- **ISSUE:**
  - `ALU_EN`=1, `ALU_OE`=0.
  - `ALU_OPCODE`/`ALU_A`/`ALU_B` show the registered values; the ALU computes at the closing edge.
  - Next state: CAPTURE.
- **CAPTURE:**
  - `ALU_EN`=0, `ALU_OE`=1.
  - At the closing edge, register `ALU_RESULT` into `RSP_DATA` and flags into `RSP_FLAGS`.
  - For AND/OR/XOR/NOT, CF and OF are forced to 0, because the ALU does not update them for logic ops.
  - `RSP_ERR`=0. Next state: RESP.
- **RESP:**
  - `RSP_VALID`=1, and `RSP_ID`/`RSP_DATA`/`RSP_FLAGS`/`RSP_ERR` are held stable until `RSP_READY`=1 at a posedge. Then go to IDLE.
  - Both `REQx_READY` are 0.
- **ALU operand outputs:** registered. They hold their last values outside ISSUE/CAPTURE and change only on a request handshake.
- **Reset (RST_N=0 at posedge), from any state:**
  - Go to IDLE; `last`=1.
  - Outputs: `RSP_VALID`=0, `RSP_ID`=0, `RSP_DATA`=0, `RSP_FLAGS`=0, `RSP_ERR`=0, `ALU_EN`=0, `ALU_OE`=0, `ALU_OPCODE`=0, `ALU_A`=0, `ALU_B`=0, `REQx_READY`=0.
  - An in-flight operation is dropped with no response. `REQx_READY` stays 0 while `RST_N`=0.

## Timing
- **Legal op:** handshake in cycle N; ISSUE in N+1; CAPTURE in N+2; `RSP_VALID` first high in N+3.
- **Illegal op:** handshake in cycle N; `RSP_VALID` high in N+1.
- **Back-to-back:** response handshake in cycle M → IDLE in M+1, so the earliest next request handshake is M+1. Minimum legal-op period is 4 cycles with `RSP_READY` held high.
- `ALU_EN` is high for exactly one cycle per legal op; `ALU_OE` is high for exactly one cycle, the cycle after.
- A requester that drops VALID before its grant loses nothing; arbitration re-evaluates every IDLE cycle.
- Reset asserted in the same cycle as a handshake takes priority: the request is not accepted.

## Test plan
- **ADD overflow:** req0 ADD A=0x7F B=0x01 → `RSP_VALID` 3 cycles after handshake, `RSP_ID`=0, `RSP_DATA`=0x80, `RSP_FLAGS`={0,1,1,0}; `ALU_EN` pulses once, `ALU_OE` pulses the next cycle.
- **SUB borrow, then AND:**
  - req1 SUB A=0x05 B=0x07 → `RSP_DATA`=0xFE, CF=1, SF=1, ZF=0, `RSP_ID`=1.
  - Then AND A=0xF0 B=0x0F → `RSP_DATA`=0x00, `RSP_FLAGS`={0,0,0,1}.
- **Fairness:** both requesters valid continuously with ADD, `RSP_READY`=1 → grants alternate 0,1,0,1,…; each response exactly 4 cycles apart.
- **Illegal opcode:** req0 OP=`1111` → `RSP_ERR`=1, `RSP_DATA`=0, `RSP_FLAGS`=0 one cycle after handshake; `ALU_EN` and `ALU_OE` stay 0 throughout.
- **Backpressure:** `RSP_READY`=0 for 5 cycles during RESP → response outputs stable and both `REQx_READY`=0; accept resumes the cycle after `RSP_READY`=1.
- **Reset mid-operation:** `RST_N`=0 during CAPTURE → next cycle all outputs at reset values, no response emitted; first post-reset simultaneous request is granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single ALU between two requesters. One operation is in flight at
// a time: a request is accepted in IDLE, driven into the ALU for one cycle
// (ISSUE, EN=1), read back the following cycle (CAPTURE, OE=1) and returned
// on the response port (RESP) tagged with the requester ID. Illegal opcodes
// bypass the ALU and are answered directly with an error response.
//
// Ports
//   CLK, RST_N              clock, synchronous active-low reset
//   REQx_VALID/READY        request handshake for requester x (0/1)
//   REQx_OP, REQx_A/B       opcode and operands for requester x
//   RSP_VALID/READY         response handshake
//   RSP_ID                  requester that issued the operation
//   RSP_DATA, RSP_FLAGS     result and {CF, OF, SF, ZF}
//   RSP_ERR                 opcode was illegal, nothing executed
//   ALU_EN, ALU_OE          ALU compute / output-enable strobes
//   ALU_OPCODE, ALU_A/B     registered ALU operands
//   ALU_RESULT, ALU_xF      ALU result and flags
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,

  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [3:0]       REQ0_OP,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,

  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [3:0]       REQ1_OP,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,

  output logic             RSP_VALID,
  input  logic             RSP_READY,
  output logic             RSP_ID,
  output logic [WIDTH-1:0] RSP_DATA,
  output logic [3:0]       RSP_FLAGS,
  output logic             RSP_ERR,

  output logic             ALU_EN,
  output logic             ALU_OE,
  output logic [3:0]       ALU_OPCODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALU_RESULT,
  input  logic             ALU_CF,
  input  logic             ALU_OF,
  input  logic             ALU_SF,
  input  logic             ALU_ZF
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             last_q,  last_d;   // requester served most recently
  logic             id_q,    id_d;
  logic [3:0]       op_q,    op_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [3:0]       flags_q, flags_d;
  logic             err_q,   err_d;

  logic             gnt0, gnt1;
  logic             accept;
  logic             sel;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;

  // ADD..NOT occupy the contiguous range 0010..0111.
  function automatic logic op_legal(input logic [3:0] op);
    return (op >= 4'd2) && (op <= 4'd7);
  endfunction

  // AND/OR/XOR/NOT: the ALU leaves CF/OF untouched for these.
  function automatic logic op_is_logic(input logic [3:0] op);
    return (op >= 4'd4) && (op <= 4'd7);
  endfunction

  // -------------------------------------------------------------------------
  // Round-robin arbitration. On contention the requester that was not served
  // last wins; last_q resets to 1 so requester 0 wins the first contest.
  // READY is gated by RST_N so nothing is acknowledged while reset is held.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt0       = REQ0_VALID && (!REQ1_VALID || last_q);
    gnt1       = REQ1_VALID && (!REQ0_VALID || !last_q);
    REQ0_READY = RST_N && (state_q == IDLE) && gnt0;
    REQ1_READY = RST_N && (state_q == IDLE) && gnt1;
    accept     = REQ0_READY || REQ1_READY;
    sel        = REQ1_READY;
    sel_op     = sel ? REQ1_OP : REQ0_OP;
    sel_a      = sel ? REQ1_A  : REQ0_A;
    sel_b      = sel ? REQ1_B  : REQ0_B;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    flags_d = flags_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d   = sel;
          last_d = sel;
          op_d   = sel_op;
          a_d    = sel_a;
          b_d    = sel_b;
          if (op_legal(sel_op)) begin
            state_d = ISSUE;
          end else begin
            // Error response is built here; the ALU strobes never fire.
            state_d = RESP;
            data_d  = '0;
            flags_d = '0;
            err_d   = 1'b1;
          end
        end
      end

      ISSUE: begin
        state_d = CAPTURE;
      end

      CAPTURE: begin
        data_d  = ALU_RESULT;
        flags_d = {op_is_logic(op_q) ? 1'b0 : ALU_CF,
                   op_is_logic(op_q) ? 1'b0 : ALU_OF,
                   ALU_SF,
                   ALU_ZF};
        err_d   = 1'b0;
        state_d = RESP;
      end

      RESP: begin
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: strobes decode the state register, operands come straight from
  // the request registers so they only move on a request handshake.
  // -------------------------------------------------------------------------
  assign ALU_EN     = (state_q == ISSUE);
  assign ALU_OE     = (state_q == CAPTURE);
  assign ALU_OPCODE = op_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;

  assign RSP_VALID  = (state_q == RESP);
  assign RSP_ID     = id_q;
  assign RSP_DATA   = data_q;
  assign RSP_FLAGS  = flags_q;
  assign RSP_ERR    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed stimulus with hand-computed expected responses pushed into a
// scoreboard queue; a negedge monitor pops and compares every response
// handshake and tracks latency and the ALU strobe sequence. A small ALU
// model answers the DUT; like the real ALU it leaves CF/OF unchanged for
// logic operations.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         REQ0_VALID, REQ1_VALID;
  logic         REQ0_READY, REQ1_READY;
  logic [3:0]   REQ0_OP, REQ1_OP;
  logic [W-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic         RSP_VALID, RSP_READY, RSP_ID, RSP_ERR;
  logic [W-1:0] RSP_DATA;
  logic [3:0]   RSP_FLAGS;
  logic         ALU_EN, ALU_OE;
  logic [3:0]   ALU_OPCODE;
  logic [W-1:0] ALU_A, ALU_B;
  logic [W-1:0] ALU_RESULT;
  logic         ALU_CF, ALU_OF, ALU_SF, ALU_ZF;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_OP(REQ0_OP),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_OP(REQ1_OP),
    .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_DATA(RSP_DATA), .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_RESULT(ALU_RESULT),
    .ALU_CF(ALU_CF), .ALU_OF(ALU_OF), .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF)
  );

  always #5 CLK = ~CLK;

  // ---------------- ALU model ----------------
  logic [W:0]   m_sum, m_dif;
  logic [W-1:0] m_res;
  assign m_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
  assign m_dif = {1'b0, ALU_A} - {1'b0, ALU_B};
  always_comb begin
    m_res = '0;
    case (ALU_OPCODE)
      4'h2: m_res = m_sum[W-1:0];
      4'h3: m_res = m_dif[W-1:0];
      4'h4: m_res = ALU_A & ALU_B;
      4'h5: m_res = ALU_A | ALU_B;
      4'h6: m_res = ALU_A ^ ALU_B;
      4'h7: m_res = ~ALU_A;
      default: m_res = '0;
    endcase
  end

  initial begin
    ALU_RESULT = '0; ALU_CF = 1'b0; ALU_OF = 1'b0; ALU_SF = 1'b0; ALU_ZF = 1'b0;
  end

  always @(posedge CLK) begin
    if (ALU_EN) begin
      ALU_RESULT <= m_res;
      ALU_SF     <= m_res[W-1];
      ALU_ZF     <= (m_res == '0);
      if (ALU_OPCODE == 4'h2) begin
        ALU_CF <= m_sum[W];
        ALU_OF <= (ALU_A[W-1] == ALU_B[W-1]) && (m_sum[W-1] != ALU_A[W-1]);
      end else if (ALU_OPCODE == 4'h3) begin
        ALU_CF <= m_dif[W];
        ALU_OF <= (ALU_A[W-1] != ALU_B[W-1]) && (m_dif[W-1] != ALU_A[W-1]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic         id;
    logic [W-1:0] data;
    logic [3:0]   flags;
    logic         err;
    int           lat;
  } exp_t;

  exp_t expq[$];
  int   rsp_cycq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hs_cyc = 0;
  int   en_cnt = 0;
  int   oe_cnt = 0;
  logic prev_en = 1'b0;
  logic prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    exp_t e;
    chk("ready_exclusive", {31'd0, REQ0_READY & REQ1_READY}, 32'd0);
    if ((REQ0_VALID && REQ0_READY) || (REQ1_VALID && REQ1_READY)) hs_cyc = cyc;
    if (ALU_EN) en_cnt++;
    if (ALU_OE) begin
      oe_cnt++;
      chk("oe_follows_en", {31'd0, prev_en}, 32'd1);
    end
    if (prev_en) chk("en_one_cycle", {31'd0, ALU_EN}, 32'd0);
    prev_en = ALU_EN;
    if (RSP_VALID && !prev_valid) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h, none expected", RSP_ID, RSP_DATA);
      end else begin
        chk("rsp_latency", cyc - hs_cyc, expq[0].lat);
      end
    end
    if (RSP_VALID && RSP_READY && expq.size() != 0) begin
      e = expq.pop_front();
      chk("rsp_id",    {31'd0, RSP_ID},    {31'd0, e.id});
      chk("rsp_data",  {24'd0, RSP_DATA},  {24'd0, e.data});
      chk("rsp_flags", {28'd0, RSP_FLAGS}, {28'd0, e.flags});
      chk("rsp_err",   {31'd0, RSP_ERR},   {31'd0, e.err});
      rsp_cycq.push_back(cyc);
    end
    prev_valid = RSP_VALID;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic id, input logic [W-1:0] d, input logic [3:0] f,
                      input logic err, input int lat);
    exp_t e;
    e.id = id; e.data = d; e.flags = f; e.err = err; e.lat = lat;
    expq.push_back(e);
  endtask

  task automatic drive(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    if (id) begin REQ1_VALID = 1'b1; REQ1_OP = op; REQ1_A = a; REQ1_B = b; end
    else    begin REQ0_VALID = 1'b1; REQ0_OP = op; REQ0_A = a; REQ0_B = b; end
  endtask

  task automatic send(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] ed,
                      input logic [3:0] ef, input logic ee, input int lat);
    logic ok;
    @(posedge CLK); #1;
    drive(id, op, a, b);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (id ? REQ1_READY : REQ0_READY) begin ok = 1'b1; break; end
    end
    chk("grant_wait", {31'd0, ok}, 32'd1);
    if (ok) push(id, ed, ef, ee, lat);
    @(posedge CLK); #1;
    if (id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (expq.size() == 0) break;
    end
    chk("drain_pending", expq.size(), 0);
    expq.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic         s_id, s_err, ok;
    logic [W-1:0] s_data;
    logic [3:0]   s_flags;
    int           n, en0, oe0, s;

    RST_N = 1'b0; RSP_READY = 1'b1;
    REQ0_VALID = 1'b0; REQ0_OP = '0; REQ0_A = '0; REQ0_B = '0;
    REQ1_VALID = 1'b0; REQ1_OP = '0; REQ1_A = '0; REQ1_B = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_rsp_valid", {31'd0, RSP_VALID}, 32'd0);
    chk("reset_alu_en_oe", {30'd0, ALU_EN, ALU_OE}, 32'd0);
    chk("reset_alu_ops",   {12'd0, ALU_OPCODE, ALU_A, ALU_B}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // ADD signed overflow
    send(1'b0, 4'h2, 8'h7F, 8'h01, 8'h80, 4'b0110, 1'b0, 3);
    drain();
    // SUB with borrow, then AND giving zero
    send(1'b1, 4'h3, 8'h05, 8'h07, 8'hFE, 4'b1010, 1'b0, 3);
    drain();
    send(1'b1, 4'h4, 8'hF0, 8'h0F, 8'h00, 4'b0001, 1'b0, 3);
    drain();

    // Fairness: both always valid; last served was 1, so order is 0,1,0,1
    @(posedge CLK); #1;
    drive(1'b0, 4'h2, 8'h10, 8'h20);
    drive(1'b1, 4'h2, 8'hFF, 8'h01);
    for (int k = 0; k < 2; k++) begin
      push(1'b0, 8'h30, 4'b0000, 1'b0, 3);
      push(1'b1, 8'h00, 4'b1001, 1'b0, 3);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (REQ0_READY || REQ1_READY) n++;
      if (n == 4) break;
    end
    chk("fair_handshakes", n, 4);
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    drain();
    s = rsp_cycq.size();
    for (int k = s - 3; k < s; k++) chk("fair_period", rsp_cycq[k] - rsp_cycq[k-1], 4);

    // Illegal opcode: error response one cycle after handshake, ALU untouched
    en0 = en_cnt; oe0 = oe_cnt;
    send(1'b0, 4'hF, 8'h12, 8'h34, 8'h00, 4'b0000, 1'b1, 1);
    drain();
    chk("illegal_no_en", en_cnt - en0, 0);
    chk("illegal_no_oe", oe_cnt - oe0, 0);

    // Backpressure: response held 5 cycles while req0 waits
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    send(1'b1, 4'h5, 8'hA5, 8'h0F, 8'hAF, 4'b0010, 1'b0, 3);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RSP_VALID) begin ok = 1'b1; break; end
    end
    chk("bp_rsp_valid", {31'd0, ok}, 32'd1);
    s_id = RSP_ID; s_data = RSP_DATA; s_flags = RSP_FLAGS; s_err = RSP_ERR;
    @(posedge CLK); #1;
    drive(1'b0, 4'h6, 8'h3C, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_stable", {17'd0, RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAGS, RSP_ERR},
                       {17'd0, 1'b1, s_id, s_data, s_flags, s_err});
      chk("bp_no_ready", {30'd0, REQ0_READY, REQ1_READY}, 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (REQ0_READY) begin ok = 1'b1; break; end
    end
    chk("bp_accept_seen", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("bp_accept_cycle", cyc - rsp_cycq[rsp_cycq.size()-1], 1);
      push(1'b0, 8'h00, 4'b0001, 1'b0, 3);
    end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    drain();

    // Reset during CAPTURE: operation dropped, then req0 wins the first contest
    @(posedge CLK); #1;
    drive(1'b0, 4'h2, 8'h01, 8'h02);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (REQ0_READY) break;
    end
    @(posedge CLK); #1;
    REQ0_VALID = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ALU_OE) begin ok = 1'b1; break; end
    end
    chk("rst_capture_seen", {31'd0, ok}, 32'd1);
    RST_N = 1'b0;
    drive(1'b0, 4'h7, 8'h0F, 8'h00);
    drive(1'b1, 4'h3, 8'h03, 8'h03);
    @(negedge CLK);
    chk("rst_rsp_regs", {19'd0, RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAGS, RSP_ERR}, 32'd0);
    chk("rst_alu_strobes", {30'd0, ALU_EN, ALU_OE}, 32'd0);
    chk("rst_alu_ops", {12'd0, ALU_OPCODE, ALU_A, ALU_B}, 32'd0);
    chk("rst_no_ready", {30'd0, REQ0_READY, REQ1_READY}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    push(1'b0, 8'hF0, 4'b0010, 1'b0, 3);
    push(1'b1, 8'h00, 4'b0001, 1'b0, 3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (REQ0_READY) begin
        n++;
        @(posedge CLK); #1; REQ0_VALID = 1'b0;
      end else if (REQ1_READY) begin
        n++;
        @(posedge CLK); #1; REQ1_VALID = 1'b0;
      end
      if (n == 2) break;
    end
    chk("rst_post_handshakes", n, 2);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    drain();

    chk("en_pulse_count", en_cnt, 12);
    chk("oe_pulse_count", oe_cnt, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
